song_player: RTL
================

SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter SIXTEENTH_TICKS, default 12_500_000: clk cycles per sixteenth-note unit (125 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 1_250_000: silent articulation cycles at the end of every note; legal range 0..SIXTEENTH_TICKS-1.
REQ-003 SHALL have ports, in this order:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- song_sel  in  SONG_BITS  song requested at start
- start  in  1  one-cycle play request
- pause  in  1  level; high freezes playback
- stop  in  1  one-cycle abort
- loop_en  in  1  level; restart at index 0 after last note
- song  out  SONG_BITS  registered song code to the score ROM
- cnt  out  SONG_CNT_BITS  registered note index to the score ROM
- track  in  SONG_CNT_BITS  note count from the ROM
- octave  in  OCTAVE_BITS  note octave from the ROM
- note  in  NOTE_BITS  note pitch code from the ROM
- length  in  LENGTH_BITS  note length code from the ROM
- full_note  in  FULL_NOTE_BITS  whole-note length code from the ROM
- tone_valid  out  1  high while a pitch sounds
- tone_octave  out  OCTAVE_BITS  held octave
- tone_note  out  NOTE_BITS  held pitch code
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when playback ends or is refused

Function
REQ-004 SHALL treat the score ROM as zero-latency combinational: ROM outputs are sampled in the cycle after cnt/song change.
REQ-005 SHALL implement states IDLE, LOAD, SOUND, GAP, PAUSED.
REQ-006 IDLE: on start with stop low, register song<=song_sel and cnt<=0, then go to LOAD next cycle.
REQ-007 LOAD (exactly 1 cycle): if track==0, pulse done and go to IDLE; otherwise capture octave and note into tone_octave/tone_note, compute the duration, then go to SOUND.
REQ-008 Duration SHALL be D = SIXTEENTH_TICKS * 2^(full_note-length) when length<=full_note, else SIXTEENTH_TICKS; width sized for 16*SIXTEENTH_TICKS without overflow.
REQ-009 SOUND SHALL last D-GAP_TICKS cycles with tone_valid=1, then enter GAP. If GAP_TICKS==0, GAP is skipped.
REQ-010 GAP SHALL last GAP_TICKS cycles with tone_valid=0.
REQ-011 At GAP end: if cnt<track-1, increment cnt and go to LOAD; else if loop_en, set cnt<=0 and go to LOAD; else pulse done and go to IDLE.
REQ-012 pause high in SOUND or GAP: next cycle go to PAUSED; the tick counter and cnt freeze and tone_valid=0. On pause low, return to the saved state and resume the remaining count.
REQ-013 pause in IDLE or LOAD SHALL be ignored until the next SOUND/GAP cycle.
REQ-014 stop in any non-IDLE state: next cycle go to IDLE, tone_valid=0, pulse done; stop has priority over start and pause.
REQ-015 start while busy SHALL be ignored; song SHALL NOT change while busy.
REQ-016 tone_octave/tone_note SHALL hold their last values in IDLE.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE and clear the counters. Reset values:
- song=0, cnt=0
- tone_valid=0, tone_octave=0, tone_note=0
- busy=0, done=0
REQ-018 Release from reset SHALL leave the block idle; a start asserted during reset is lost.

Structure
REQ-019 SONG_BITS, SONG_CNT_BITS, OCTAVE_BITS, NOTE_BITS, LENGTH_BITS, FULL_NOTE_BITS and the song/length codes SHALL come from Constants.vh; the state encoding SHALL be added there.
REQ-020 The tick/duration counter SHALL be one sub-module, note_timer (load, enable, expire), instantiated once.

Verification (SIXTEENTH_TICKS=4, GAP_TICKS=1, full_note=4)
REQ-021 little_star, start, ROM connected -> 42 notes; quarter note = 15 cycles tone_valid + 1 gap; half note = 31 + 1; single done after index 41; busy falls the same cycle.
REQ-022 two_tigers with loop_en=1 -> after index 31, cnt returns to 0 with no done pulse; loop_en dropped mid-song -> done after index 31.
REQ-023 pause held 10 cycles, mid-SOUND at remaining count 5 -> tone_valid low for 10 cycles, then exactly 5 more sound cycles; cnt unchanged.
REQ-024 stop and start in the same cycle mid-song -> IDLE next cycle, done=1 for 1 cycle, tone_valid=0, no restart.
REQ-025 song code with track=0, start -> done pulse 2 cycles after start, tone_valid never high.
REQ-026 rst_n pulsed low mid-SOUND -> all outputs equal reset values immediately (asynchronously); a later start replays from cnt=0.

Source files
------------

// File: rtl/song_player_pkg.sv
// Shared widths, song/length codes, FSM state encoding and duration helper for song_player.
package song_player_pkg;

   localparam int SONG_BITS      = 2;
   localparam int SONG_CNT_BITS  = 6;
   localparam int OCTAVE_BITS    = 2;
   localparam int NOTE_BITS      = 4;
   localparam int LENGTH_BITS    = 3;
   localparam int FULL_NOTE_BITS = 3;

   localparam logic [SONG_BITS-1:0] SONG_NONE        = 2'd0;
   localparam logic [SONG_BITS-1:0] SONG_LITTLE_STAR = 2'd1;
   localparam logic [SONG_BITS-1:0] SONG_TWO_TIGERS  = 2'd2;
   localparam logic [SONG_BITS-1:0] SONG_SPARE       = 2'd3;

   // Length codes as stored by the score ROM when full_note = FULL_NOTE_CODE.
   localparam logic [FULL_NOTE_BITS-1:0] FULL_NOTE_CODE = 3'd4;
   localparam logic [LENGTH_BITS-1:0]    LEN_WHOLE      = 3'd0;
   localparam logic [LENGTH_BITS-1:0]    LEN_HALF       = 3'd1;
   localparam logic [LENGTH_BITS-1:0]    LEN_QUARTER    = 3'd2;
   localparam logic [LENGTH_BITS-1:0]    LEN_EIGHTH     = 3'd3;
   localparam logic [LENGTH_BITS-1:0]    LEN_SIXTEENTH  = 3'd4;

   // Longest note is a whole note = 16 sixteenths, i.e. a shift of 4.
   localparam int MAX_SHIFT = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SOUND  = 3'd2,
      ST_GAP    = 3'd3,
      ST_PAUSED = 3'd4
   } state_t;

   // Power-of-two multiplier of the sixteenth unit; a length shorter than a
   // sixteenth plays as one sixteenth, and the shift is capped so the
   // duration register never overflows.
   function automatic logic [2:0] dur_shift(input logic [LENGTH_BITS-1:0]    len,
                                            input logic [FULL_NOTE_BITS-1:0] full);
      logic [FULL_NOTE_BITS-1:0] diff;
      if (len > full) return 3'd0;
      diff = full - len;
      return (diff > 3'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : diff;
   endfunction

endpackage

// File: rtl/song_player_note_timer.sv
// Down-counting tick timer; expire flags the last enabled cycle of a loaded interval.
module note_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         enable,
   output logic         expire
);

   logic [W-1:0] count;

   // Load has priority; count freezes whenever enable is low (pause).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expire = enable && (count == W'(1));

endmodule

// File: rtl/song_player.sv
// Score-ROM sequencer: walks a song note by note, holding each pitch for its
// duration minus a short silent articulation gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; tone outputs hold the last note
// LOAD    | one cycle: ROM sampled, pitch captured, sound timer loaded
// SOUND   | pitch sounding, timer counting down D-GAP_TICKS cycles
// GAP     | silent articulation, GAP_TICKS cycles
// PAUSED  | timer and cnt frozen; resume_q holds where to return
module song_player
   import song_player_pkg::*;
#(
   parameter int SIXTEENTH_TICKS = 12_500_000,
   parameter int GAP_TICKS       = 1_250_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SONG_BITS-1:0]      song_sel,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      stop,
   input  logic                      loop_en,
   output logic [SONG_BITS-1:0]      song,
   output logic [SONG_CNT_BITS-1:0]  cnt,
   input  logic [SONG_CNT_BITS-1:0]  track,
   input  logic [OCTAVE_BITS-1:0]    octave,
   input  logic [NOTE_BITS-1:0]      note,
   input  logic [LENGTH_BITS-1:0]    length,
   input  logic [FULL_NOTE_BITS-1:0] full_note,
   output logic                      tone_valid,
   output logic [OCTAVE_BITS-1:0]    tone_octave,
   output logic [NOTE_BITS-1:0]      tone_note,
   output logic                      busy,
   output logic                      done
);

   localparam int DUR_W = $clog2(16 * SIXTEENTH_TICKS + 1);

   state_t             state_q, state_d, resume_q, resume_d;
   logic               tmr_load, tmr_en, tmr_expire;
   logic [DUR_W-1:0]   tmr_val, dur, sound_len;
   logic [SONG_CNT_BITS:0] cnt_inc;
   logic               last_note, note_end;

   assign dur       = DUR_W'(SIXTEENTH_TICKS) << dur_shift(length, full_note);
   assign sound_len = dur - DUR_W'(GAP_TICKS);
   assign cnt_inc   = {1'b0, cnt} + (SONG_CNT_BITS + 1)'(1);
   assign last_note = (cnt_inc >= {1'b0, track});
   assign note_end  = tmr_expire && ((state_q == ST_GAP) ||
                                     ((state_q == ST_SOUND) && (GAP_TICKS == 0)));

   note_timer #(.W(DUR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .enable   (tmr_en),
      .expire   (tmr_expire)
   );

   // State and resume-target registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         resume_q <= ST_IDLE;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
      end
   end

   // Next-state: stop beats everything; a pause that lands on a segment's
   // last cycle parks the FSM in PAUSED aimed at the following segment.
   always_comb begin
      state_t seg_next;
      state_t end_state;
      state_d   = state_q;
      resume_d  = resume_q;
      end_state = (!last_note || loop_en) ? ST_LOAD : ST_IDLE;
      seg_next  = ((state_q == ST_SOUND) && (GAP_TICKS != 0)) ? ST_GAP : end_state;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (stop || (track == '0)) state_d = ST_IDLE;
            else                       state_d = ST_SOUND;
         end
         ST_SOUND, ST_GAP: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (tmr_expire) begin
               if (pause && (seg_next != ST_IDLE)) begin
                  state_d  = ST_PAUSED;
                  resume_d = seg_next;
               end else begin
                  state_d = seg_next;
               end
            end else if (pause) begin
               state_d  = ST_PAUSED;
               resume_d = state_q;
            end
         end
         ST_PAUSED: begin
            if (stop)        state_d = ST_IDLE;
            else if (!pause) state_d = resume_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and timer control decoded from the current state.
   always_comb begin
      tone_valid = (state_q == ST_SOUND);
      busy       = (state_q != ST_IDLE);
      tmr_en     = (state_q == ST_SOUND) || (state_q == ST_GAP);
      tmr_load   = 1'b0;
      tmr_val    = sound_len;
      if (state_q == ST_LOAD) begin
         tmr_load = 1'b1;
      end else if ((state_q == ST_SOUND) && tmr_expire && (GAP_TICKS != 0)) begin
         tmr_load = 1'b1;
         tmr_val  = DUR_W'(GAP_TICKS);
      end
   end

   // Song/index registers to the ROM, captured pitch and the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         song        <= '0;
         cnt         <= '0;
         tone_octave <= '0;
         tone_note   <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (start && !stop) begin
               song <= song_sel;
               cnt  <= '0;
            end
         end else if (stop) begin
            done <= 1'b1;
         end else if (state_q == ST_LOAD) begin
            if (track == '0) begin
               done <= 1'b1;
            end else begin
               tone_octave <= octave;
               tone_note   <= note;
            end
         end else if (note_end) begin
            if (!last_note)   cnt  <= cnt + SONG_CNT_BITS'(1);
            else if (loop_en) cnt  <= '0;
            else              done <= 1'b1;
         end
      end
   end

endmodule
